// File: rtl/buffer_link_arbiter_pkg.sv
// rtl/buffer_link_arbiter_pkg.sv - shared types and constants for the buffer link arbiter
package buffer_pkg;

  localparam int NUM_LINKS = 4;
  localparam int LINK_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SINGLE  = 2'd1,
    PAIR_LO = 2'd2,
    PAIR_HI = 2'd3
  } arb_state_t;

  function automatic logic [NUM_LINKS-1:0] link_onehot(input logic [LINK_W-1:0] idx);
    return NUM_LINKS'(1) << idx;
  endfunction

endpackage

// File: rtl/buffer_link_arbiter_if.sv
// rtl/buffer_link_arbiter_if.sv - link request / grant / buffer write-port bundle
interface buffer_link_arbiter_if;
  import buffer_pkg::*;

  logic [NUM_LINKS-1:0] req;
  logic                 multi_width;
  logic                 buf_full;
  logic [NUM_LINKS-1:0] grant;
  logic [LINK_W-1:0]    link_num;
  logic                 wr_en;

  modport master (
    output req, multi_width, buf_full,
    input  grant, link_num, wr_en
  );

  modport slave (
    input  req, multi_width, buf_full,
    output grant, link_num, wr_en
  );

endinterface

// File: rtl/buffer_link_arbiter_rr_pick.sv
// rtl/buffer_link_arbiter_rr_pick.sv - rotate-priority encoder, first set bit at or after start
module buffer_rr_pick
  import buffer_pkg::*;
(
  input  logic [NUM_LINKS-1:0] req_vec,
  input  logic [LINK_W-1:0]    start,
  output logic                 valid,
  output logic [LINK_W-1:0]    idx
);

  logic [LINK_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = NUM_LINKS - 1; i >= 0; i--) begin
      cand = start + LINK_W'(i);
      if (req_vec[cand]) idx = cand;
    end
  end

  assign valid = |req_vec;

endmodule

// File: rtl/buffer_link_arbiter.sv
// rtl/buffer_link_arbiter.sv - round-robin arbiter for the shared buffer write port
// Optional per-link saturating word counters on stat_cnt when BUFFER_ARB_STATS_EN is defined.
module buffer_link_arbiter
  import buffer_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  buffer_link_arbiter_if.slave       bus
`ifdef BUFFER_ARB_STATS_EN
  ,
  output logic [NUM_LINKS*CNT_W-1:0] stat_cnt
`endif
);

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);

  arb_state_t           state;
  logic [LINK_W-1:0]    ptr;
  logic [LINK_W-1:0]    link_q;
  logic [NUM_LINKS-1:0] grant_q;
  logic [3:0]           beat;
  logic [3:0]           beat_inc;

  logic                 s_valid;
  logic                 p_valid;
  logic [LINK_W-1:0]    s_idx;
  logic [LINK_W-1:0]    p_idx;
  logic [NUM_LINKS-1:0] pair_req;
  logic [LINK_W-1:0]    lo_link;
  logic [LINK_W-1:0]    hi_link;
  logic                 pair_ok;
  logic                 accept;

  assign pair_req = {2'b00, bus.req[3] & bus.req[2], bus.req[1] & bus.req[0]};
  assign lo_link  = {link_q[1], 1'b0};
  assign hi_link  = {link_q[1], 1'b1};
  assign pair_ok  = bus.req[lo_link] & bus.req[hi_link];
  assign accept   = (|(grant_q & bus.req)) & ~bus.buf_full;
  assign beat_inc = beat + 4'd1;

  assign bus.wr_en    = accept;
  assign bus.grant    = grant_q;
  assign bus.link_num = link_q;

  buffer_rr_pick u_single_pick (
    .req_vec (bus.req),
    .start   (ptr),
    .valid   (s_valid),
    .idx     (s_idx)
  );

  // Pair selection reuses the encoder on a two-entry vector; pair p maps to link 2p.
  buffer_rr_pick u_pair_pick (
    .req_vec (pair_req),
    .start   ({1'b0, ptr[1]}),
    .valid   (p_valid),
    .idx     (p_idx)
  );

  // Back-pressure freezes the whole scheduler; a grant is never withdrawn while full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      beat    <= '0;
      grant_q <= '0;
      link_q  <= '0;
    end else if (!bus.buf_full) begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (!bus.multi_width && s_valid) begin
            state   <= SINGLE;
            grant_q <= link_onehot(s_idx);
            link_q  <= s_idx;
          end else if (bus.multi_width && p_valid) begin
            state   <= PAIR_LO;
            grant_q <= link_onehot({p_idx[0], 1'b0});
            link_q  <= {p_idx[0], 1'b0};
          end else begin
            grant_q <= '0;
            link_q  <= '0;
          end
        end
        SINGLE: begin
          if (!accept || beat_inc == BURST_LAST) begin
            state   <= IDLE;
            grant_q <= '0;
            link_q  <= '0;
            beat    <= '0;
            ptr     <= link_q + 2'd1;
          end else begin
            beat <= beat_inc;
          end
        end
        PAIR_LO: begin
          if (!pair_ok) begin
            state   <= IDLE;
            grant_q <= '0;
            link_q  <= '0;
          end else begin
            state   <= PAIR_HI;
            grant_q <= link_onehot(hi_link);
            link_q  <= hi_link;
          end
        end
        PAIR_HI: begin
          // The high word must land once the low word has; a missing high request only stalls.
          if (accept) begin
            if (beat_inc == BURST_LAST || !pair_ok) begin
              state   <= IDLE;
              grant_q <= '0;
              link_q  <= '0;
              beat    <= '0;
              ptr     <= {~link_q[1], 1'b0};
            end else begin
              state   <= PAIR_LO;
              grant_q <= link_onehot(lo_link);
              link_q  <= lo_link;
              beat    <= beat_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUFFER_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_LINKS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LINKS; i++) cnt[i] <= '0;
    end else if (accept && cnt[link_q] != '1) begin
      cnt[link_q] <= cnt[link_q] + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_stat
    assign stat_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
  end
`endif

endmodule

// File: tb/tb_buffer_link_arbiter.sv
// tb/tb_buffer_link_arbiter.sv - directed self-checking bench for buffer_link_arbiter
module tb_buffer_link_arbiter;

`ifdef BUFFER_ARB_STATS_EN
  localparam int CNT_W = 4;
  logic [4*CNT_W-1:0] stat_cnt;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  buffer_link_arbiter_if bus ();

  buffer_link_arbiter #(
    .BURST_LEN (4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef BUFFER_ARB_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] r, input logic mw, input logic full);
    bus.req         = r;
    bus.multi_width = mw;
    bus.buf_full    = full;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_link", 32'(bus.link_num), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic expect_write(input string tag, input logic [3:0] g, input logic [1:0] l);
    check({tag, "_grant"}, 32'(bus.grant), 32'(g));
    check({tag, "_link"}, 32'(bus.link_num), 32'(l));
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'h1);
  endtask

  task automatic expect_gap(input string tag);
    check({tag, "_gap_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_gap_wr_en"}, 32'(bus.wr_en), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    int nw;

    // Single mode, all links requesting: 0,1,2,3,0 with 4 writes and one gap each.
    do_reset();
    drive(4'b1111, 1'b0, 1'b0);
    check("lat_no_grant_yet", 32'(bus.grant), 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int w = 0; w < 4; w++) begin
        expect_write("rr", exp_g, 2'(k % 4));
        step();
      end
      expect_gap("rr");
      if (k == 4) drive(4'b0000, 1'b0, 1'b0);
      step();
    end

    // Only link 2 requesting: repeated 4-write bursts with a gap.
    drive(4'b0100, 1'b0, 1'b0);
    step();
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 4; w++) begin
        expect_write("solo2", 4'b0100, 2'd2);
        step();
      end
      expect_gap("solo2");
      if (r == 1) drive(4'b0000, 1'b0, 1'b0);
      step();
    end

    // Paired mode on links 0+1: 0,1 alternating for 8 writes, then idle.
    do_reset();
    drive(4'b0011, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 2);
      expect_write("pair0", exp_g, 2'(k % 2));
      step();
    end
    expect_gap("pair0");
    drive(4'b0111, 1'b1, 1'b0);
    step();
    for (int c = 0; c < 12; c++) begin
      check("no_pair1", 32'(bus.grant[3:2]), 32'h0);
      step();
    end
    check("pre_rst_busy", 32'(|bus.grant), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_grant", 32'(bus.grant), 32'h0);
    check("async_rst_link", 32'(bus.link_num), 32'h0);
    check("async_rst_wr_en", 32'(bus.wr_en), 32'h0);

    // Back-pressure on link 1: 3-cycle stall mid-burst, then full on the last beat.
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    step();
    expect_write("bp", 4'b0010, 2'd1);
    step();
    expect_write("bp", 4'b0010, 2'd1);
    step();
    drive(4'b0010, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("bp_stall_wr_en", 32'(bus.wr_en), 32'h0);
      check("bp_stall_grant", 32'(bus.grant), 32'h2);
      step();
    end
    drive(4'b0010, 1'b0, 1'b0);
    expect_write("bp_resume", 4'b0010, 2'd1);
    step();
    drive(4'b0010, 1'b0, 1'b1);
    check("bp_last_wr_en", 32'(bus.wr_en), 32'h0);
    check("bp_last_grant", 32'(bus.grant), 32'h2);
    step();
    drive(4'b0010, 1'b0, 1'b0);
    expect_write("bp_last", 4'b0010, 2'd1);
    step();
    expect_gap("bp_end");
    drive(4'b0000, 1'b0, 1'b0);

    // PAIR_HI with req[1] dropped for two cycles: stall, then the pair completes.
    do_reset();
    drive(4'b0011, 1'b1, 1'b0);
    step();
    expect_write("hi_lo", 4'b0001, 2'd0);
    step();
    drive(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      check("hi_stall_grant", 32'(bus.grant), 32'h2);
      check("hi_stall_wr_en", 32'(bus.wr_en), 32'h0);
      step();
    end
    drive(4'b0011, 1'b1, 1'b0);
    expect_write("hi_done", 4'b0010, 2'd1);
    step();
    expect_write("hi_next_lo", 4'b0001, 2'd0);

`ifdef BUFFER_ARB_STATS_EN
    // Saturating counter on link 3: 20 writes into a 4-bit counter.
    do_reset();
    drive(4'b1000, 1'b0, 1'b0);
    nw = 0;
    for (int c = 0; c < 100 && nw < 20; c++) begin
      if (bus.wr_en) nw++;
      step();
    end
    check("stat_writes", 32'(nw), 32'd20);
    check("stat_link3_sat", 32'(stat_cnt[15:12]), 32'hF);
    check("stat_others", 32'(stat_cnt[11:0]), 32'h0);
    #2 rst = 1'b0;
    #1;
    check("stat_async_rst", 32'(stat_cnt), 32'h0);
`else
    nw = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
